// File: rtl/sprite_rom_arbiter_if.sv
// sprite_rom_arbiter_if: requester and ROM side signals of the sprite ROM arbiter
interface sprite_rom_arbiter_if #(
   parameter int NREQ = 4,
   parameter int AW = 12,
   parameter int DW = 12
);
   logic [NREQ-1:0] req;
   logic [NREQ*AW-1:0] addr;
   logic [NREQ-1:0] gnt;
   logic [NREQ-1:0] rvalid;
   logic [DW-1:0] rdata;
   logic rom_en;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_data;
   modport master (output req, addr, rom_data, input gnt, rvalid, rdata, rom_en, rom_addr);
   modport slave (input req, addr, rom_data, output gnt, rvalid, rdata, rom_en, rom_addr);
endinterface

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: one-read-per-clock sprite ROM sharing with renderer priority and starvation guard
module sprite_rom_arbiter #(
   parameter int NREQ = 4,
   parameter int AW = 12,
   parameter int DW = 12,
   parameter int ROM_LAT = 1,
   parameter int STARVE = 8
) (
   input logic clk,
   input logic reset,
   sprite_rom_arbiter_if.slave bus
);
   localparam int WW = $clog2(STARVE + 1);
   localparam int PW = $clog2(NREQ);
   localparam logic [WW-1:0] WMAX = WW'(STARVE);
   localparam logic [PW-1:0] PLAST = PW'(NREQ - 1);
   logic [PW-1:0] rr_ptr, win, starve_idx, rr_idx;
   logic starve_hit, rr_hit;
   logic [WW-1:0] wait_cnt [1:NREQ-1];
   logic [NREQ-1:0] tag [ROM_LAT];
   logic [NREQ-1:0] gnt;
   logic [AW-1:0] rom_addr;
   // pick a starving requester first, then the renderer, then round-robin from rr_ptr
   always_comb begin
      starve_hit = 1'b0;
      starve_idx = '0;
      rr_hit = 1'b0;
      rr_idx = '0;
      for (int i = NREQ - 1; i >= 1; i--)
         if (bus.req[i] && wait_cnt[i] >= WMAX) begin
            starve_hit = 1'b1;
            starve_idx = PW'(i);
         end
      for (int k = NREQ - 2; k >= 0; k--)
         if (bus.req[(int'(rr_ptr) - 1 + k) % (NREQ - 1) + 1]) begin
            rr_hit = 1'b1;
            rr_idx = PW'((int'(rr_ptr) - 1 + k) % (NREQ - 1) + 1);
         end
      win = starve_hit ? starve_idx : bus.req[0] ? '0 : rr_idx;
      gnt = (reset || !(starve_hit || bus.req[0] || rr_hit)) ? '0 : NREQ'(1) << win;
      rom_addr = '0;
      for (int i = 0; i < NREQ; i++)
         if (gnt[i]) rom_addr = bus.addr[i*AW +: AW];
   end
   // round-robin pointer moves just past each non-renderer winner
   always_ff @(posedge clk or posedge reset)
      if (reset) rr_ptr <= PW'(1);
      else if (|gnt[NREQ-1:1]) rr_ptr <= (win == PLAST) ? PW'(1) : win + PW'(1);
   // per-requester wait counters, saturating at the starvation threshold
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         for (int i = 1; i < NREQ; i++) wait_cnt[i] <= '0;
      end else begin
         for (int i = 1; i < NREQ; i++)
            if (!bus.req[i] || gnt[i]) wait_cnt[i] <= '0;
            else if (wait_cnt[i] != WMAX) wait_cnt[i] <= wait_cnt[i] + 1'b1;
      end
   // grant tags travel alongside the ROM read so data returns to its owner
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         for (int s = 0; s < ROM_LAT; s++) tag[s] <= '0;
      end else begin
         tag[0] <= gnt;
         for (int s = 1; s < ROM_LAT; s++) tag[s] <= tag[s-1];
      end
   assign bus.gnt = gnt;
   assign bus.rom_en = |gnt;
   assign bus.rom_addr = rom_addr;
   assign bus.rvalid = tag[ROM_LAT-1];
   assign bus.rdata = bus.rom_data;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: directed checks of grant order, latency, starvation and reset
module tb_sprite_rom_arbiter;
   typedef struct {
      int due;
      logic [3:0] v;
      logic [11:0] d;
   } ent_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int cyc = 0;
   int checks = 0;
   int passed = 0;
   ent_t q[$];
   logic [11:0] a_tab [4] = '{12'h3C1, 12'h712, 12'h0A5, 12'hFE8};
   logic [11:0] rp [2];
   sprite_rom_arbiter_if #(.NREQ(4), .AW(12), .DW(12)) ba ();
   sprite_rom_arbiter_if #(.NREQ(4), .AW(12), .DW(12)) bb ();
   sprite_rom_arbiter #(.NREQ(4), .AW(12), .DW(12), .ROM_LAT(2), .STARVE(8)) dut (
      .clk(clk), .reset(reset), .bus(ba));
   sprite_rom_arbiter #(.NREQ(4), .AW(12), .DW(12), .ROM_LAT(3), .STARVE(8)) dut3 (
      .clk(clk), .reset(reset), .bus(bb));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic logic [11:0] rom_word(input logic [11:0] x);
      return {x[3:0], x[11:4]} ^ 12'h5A3;
   endfunction
   function automatic logic [11:0] exp_addr(input logic [3:0] g);
      logic [11:0] r = '0;
      for (int i = 0; i < 4; i++) if (g[i]) r = a_tab[i];
      return r;
   endfunction
   always @(posedge clk) begin
      rp[0] <= ba.rom_en ? rom_word(ba.rom_addr) : 12'h000;
      rp[1] <= rp[0];
   end
   assign ba.rom_data = rp[1];
   assign bb.rom_data = 12'h000;
   task automatic chk(input string t, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", t, obs, exp);
   endtask
   always @(negedge clk) begin
      logic [3:0] ev;
      logic [11:0] ed;
      ev = '0;
      ed = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
         ev = q[0].v;
         ed = q[0].d;
         void'(q.pop_front());
      end
      chk("rvalid", 16'(ba.rvalid), 16'(ev));
      if (ev != 0) chk("rdata", 16'(ba.rdata), 16'(ed));
   end
   task automatic look(input logic [3:0] eg, input string t);
      chk({t, ".gnt"}, 16'(ba.gnt), 16'(eg));
      chk({t, ".rom_en"}, 16'(ba.rom_en), 16'(|eg));
      chk({t, ".rom_addr"}, 16'(ba.rom_addr), 16'(exp_addr(eg)));
      if (eg != 0) q.push_back('{cyc + 2, eg, rom_word(exp_addr(eg))});
   endtask
   task automatic step(input logic [3:0] r, input logic [3:0] eg, input string t);
      @(posedge clk);
      #1 ba.req = r;
      @(negedge clk);
      look(eg, t);
   endtask
   initial begin
      ba.req = 4'b1111;
      bb.req = 4'b0000;
      ba.addr = {a_tab[3], a_tab[2], a_tab[1], a_tab[0]};
      bb.addr = {a_tab[3], a_tab[2], a_tab[1], a_tab[0]};
      repeat (2) @(negedge clk);
      chk("rst.gnt", 16'(ba.gnt), 16'h0);
      chk("rst.rom_en", 16'(ba.rom_en), 16'h0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      look(4'b0001, "rst_rel");
      for (int k = 0; k < 6; k++) step(4'b1110, 4'(1 << (k % 3 + 1)), "rr");
      step(4'b0000, 4'b0000, "idle");
      step(4'b0100, 4'b0100, "lat");
      step(4'b0000, 4'b0000, "idle");
      step(4'b0000, 4'b0000, "idle");
      for (int k = 0; k < 10; k++) step(4'b1001, (k == 8) ? 4'b1000 : 4'b0001, "starve");
      step(4'b0000, 4'b0000, "idle");
      for (int k = 0; k < 18; k++) step(4'b0011, (k % 9 == 8) ? 4'b0010 : 4'b0001, "prio");
      step(4'b0000, 4'b0000, "idle");
      for (int k = 0; k < 12; k++)
         step(4'b1111, (k < 8 || k == 11) ? 4'b0001 : 4'(1 << (k - 7)), "multi");
      for (int k = 0; k < 4; k++) step(4'b0000, 4'b0000, "drain");
      @(posedge clk);
      #1 bb.req = 4'b0010;
      @(negedge clk);
      chk("mid.gnt", 16'(bb.gnt), 16'h2);
      @(posedge clk);
      #1 begin
         bb.req = 4'b0000;
         reset = 1'b1;
      end
      @(negedge clk);
      chk("mid.rst_gnt", 16'(bb.gnt), 16'h0);
      @(posedge clk);
      #1 reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("mid.rvalid", 16'(bb.rvalid), 16'h0);
      end
      chk("sb_empty", 16'(q.size()), 16'h0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Shares the single-port sprite/tile ROM among the Pac-Man pixel pipeline's readers: the pixel renderer (requester 0) plus the Pac-Man, ghost and maze/pellet fetch units. It issues at most one ROM read per clock. The renderer gets fixed top priority so it meets the per-pixel deadline set by vga_sync. The other requesters are served round-robin, and a starvation guard bounds their wait. Read data returns to the winning requester a fixed ROM_LAT cycles after its grant.

## Interface
- NREQ, 4, number of requesters; index 0 is the renderer (2..8)
- AW, 12, ROM address width
- DW, 12, ROM data width (one 12-bit rgb pixel)
- ROM_LAT, 1, ROM read latency in clocks (1..3)
- STARVE, 8, wait cycles after which a non-renderer requester preempts requester 0
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester read request, level
- addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW]
- gnt  out  NREQ  one-hot grant, combinational, at most one bit set
- rvalid  out  NREQ  one-hot read-data valid
- rdata  out  DW  read data, shared; meaningful only where rvalid is set
- rom_en  out  1  ROM read enable
- rom_addr  out  AW  ROM address
- rom_data  in  DW  ROM output, valid ROM_LAT cycles after rom_en

## Operation
- Request rule: requester holds req high and addr stable until it sees gnt. A cycle with gnt[i]=1 accepts exactly one read. If req[i] stays high the next cycle, that is a new request.
- Grant selection, evaluated each cycle, first match wins:
  1. Lowest index i in 1..NREQ-1 with req[i]=1 and wait[i] >= STARVE.
  2. Requester 0, if req[0]=1.
  3. Round-robin among 1..NREQ-1: first i with req[i]=1, searching from rr_ptr upward and wrapping NREQ-1 -> 1.
- rom_en = |gnt. rom_addr = addr of the granted requester, or 0 when there is no grant.
- rr_ptr: reset value 1. On any grant to i >= 1, rr_ptr <= i+1, wrapping to 1 after NREQ-1. A grant to 0 leaves rr_ptr unchanged.
- wait[i] for i >= 1:
  - Counter width clog2(STARVE+1), reset 0.
  - Increments when req[i]=1 and gnt[i]=0, saturating at STARVE.
  - Cleared on gnt[i]=1 or req[i]=0.
- Return path:
  - Tag shift register, ROM_LAT stages of NREQ bits. Stage 0 is loaded with gnt each cycle.
  - rvalid = last stage. rdata = rom_data, passed through combinationally.
  - rvalid is one-hot or zero and never aliases because at most one grant is issued per cycle.
- Back-to-back grants to the same or different requesters are legal every cycle, giving full ROM throughput.

## Timing
- Reset (async assert, sync release):
  - gnt=0, rom_en=0 while reset is high, regardless of req.
  - rvalid=0, rr_ptr=1, all wait=0, tag pipeline cleared.
- Reset mid-operation: in-flight reads are discarded and no rvalid follows them. Requesters must re-request.
- Grant latency: 0 cycles. gnt is set in the same cycle as req if the requester wins.
- Data latency: rvalid[i] rises exactly ROM_LAT cycles after the gnt[i] cycle.
- Worst-case wait for requester i >= 1 under continuous req[0]: STARVE cycles, then granted on cycle STARVE+1.
  - If several requesters starve together, they are served in index order, one per cycle.
- req dropped before grant: no grant and no return. wait clears the next cycle.
- No req asserted: rom_en=0, all state holds except wait clearing.

## Test plan
- Reset: assert reset with req=4'b1111 -> gnt=0, rom_en=0, rvalid=0. Release -> the first cycle grants 0 (gnt=4'b0001).
- Latency: ROM_LAT=2, req[2] alone with addr 0x0A5 for one cycle -> gnt=4'b0100, rom_addr=0x0A5. Two cycles later rvalid=4'b0100 and rdata equals the ROM model's word at 0x0A5.
- Round-robin: req=4'b1110 held -> grants cycle 1,2,3,1,2,3… with no grant to the same index twice in a row.
- Starvation: STARVE=8, req[0] high continuously, req[3] high from cycle 0 -> gnt[0] for cycles 0-7, gnt[3] on cycle 8, gnt[0] again from cycle 9.
- Renderer priority: req=4'b0011 -> gnt=4'b0001 every cycle until wait[1] reaches 8. Then one grant to 1 and the sequence repeats.
- Reset mid-flight: ROM_LAT=3, grant to 1, assert reset one cycle later -> no rvalid is ever produced for that read.
